// File: rtl/vga_pkg.sv
// Shared VGA raster constants and receiver state encoding, common to generator and receiver.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned RGB_W    = 9;

  typedef enum logic [1:0] {
    StSearch,
    StMeasure,
    StLocked
  } rx_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Input capture for the VGA receiver: S1 register, sync polarity normalisation and deassert edges.
// Defining VGA_RX_SYNC2FF_EN inserts two synchroniser stages ahead of S1.
module vga_sync_edge
  import vga_pkg::*;
#(
  parameter bit SyncActiveLow = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic [RGB_W-1:0] rgb_i,
  output logic             hs_edge_o,
  output logic             vs_edge_o,
  output logic [RGB_W-1:0] rgb_o
);

  logic             hs_raw, vs_raw;
  logic [RGB_W-1:0] rgb_raw;

`ifdef VGA_RX_SYNC2FF_EN
  logic [1:0]       hs_ff_q, vs_ff_q;
  logic [RGB_W-1:0] rgb_ff0_q, rgb_ff1_q;

  // Reset to the idle line level so no false deassert edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_ff_q   <= {2{SyncActiveLow}};
      vs_ff_q   <= {2{SyncActiveLow}};
      rgb_ff0_q <= '0;
      rgb_ff1_q <= '0;
    end else begin
      hs_ff_q   <= {hs_ff_q[0], hsync_i};
      vs_ff_q   <= {vs_ff_q[0], vsync_i};
      rgb_ff0_q <= rgb_i;
      rgb_ff1_q <= rgb_ff0_q;
    end
  end

  assign hs_raw  = hs_ff_q[1];
  assign vs_raw  = vs_ff_q[1];
  assign rgb_raw = rgb_ff1_q;
`else
  assign hs_raw  = hsync_i;
  assign vs_raw  = vsync_i;
  assign rgb_raw = rgb_i;
`endif

  logic             hs_s1_q, vs_s1_q, hs_prev_q, vs_prev_q;
  logic [RGB_W-1:0] rgb_s1_q;

  // S1 holds syncs as active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      rgb_s1_q  <= '0;
    end else begin
      hs_s1_q   <= hs_raw ^ SyncActiveLow;
      vs_s1_q   <= vs_raw ^ SyncActiveLow;
      hs_prev_q <= hs_s1_q;
      vs_prev_q <= vs_s1_q;
      rgb_s1_q  <= rgb_raw;
    end
  end

  assign hs_edge_o = hs_prev_q & ~hs_s1_q;
  assign vs_edge_o = vs_prev_q & ~vs_s1_q;
  assign rgb_o     = rgb_s1_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receiver: recovers raster timing from hsync/vsync, locks, and emits pixel coordinates and RGB.
// VGA_RX_SYNC2FF_EN (see vga_sync_edge) adds two input synchroniser stages.
module vga_sync_receiver
  import vga_pkg::*;
#(
  parameter int unsigned HActive       = H_ACTIVE,
  parameter int unsigned HBack         = H_BACK,
  parameter int unsigned VActive       = V_ACTIVE,
  parameter int unsigned VBack         = V_BACK,
  parameter bit          SyncActiveLow = 1'b1,
  parameter int unsigned LockFrames    = 2,
  parameter int unsigned Timeout       = 2047
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [9:0]       pix_x,
  output logic [8:0]       pix_y,
  output logic [RGB_W-1:0] pix_rgb,
  output logic             pix_valid,
  output logic             frame_start,
  output logic             locked,
  output logic [10:0]      line_len,
  output logic             err
);

  localparam logic [10:0] HMax   = 11'(Timeout);
  localparam logic [9:0]  VMax   = 10'd1023;
  localparam logic [10:0] HBegW  = 11'(HBack);
  localparam logic [10:0] HEndW  = 11'(HBack + HActive);
  localparam logic [9:0]  VBegW  = 10'(VBack);
  localparam logic [9:0]  VEndW  = 10'(VBack + VActive);
  localparam logic [3:0]  LockW  = 4'(LockFrames);

  logic             hs_edge, vs_edge;
  logic [RGB_W-1:0] rgb_s1;

  vga_sync_edge #(
    .SyncActiveLow(SyncActiveLow)
  ) u_edge (
    .clk      (clk),
    .rst      (rst),
    .hsync_i  (hsync_in),
    .vsync_i  (vsync_in),
    .rgb_i    (rgb_in),
    .hs_edge_o(hs_edge),
    .vs_edge_o(vs_edge),
    .rgb_o    (rgb_s1)
  );

  logic [10:0] h_cnt_q, h_cnt_d, line_len_q, meas_len;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        h_timeout, v_ovf;

  assign meas_len  = h_cnt_q + 11'd1;
  assign h_timeout = !hs_edge && (h_cnt_q == HMax - 11'd1);
  assign v_ovf     = hs_edge && !vs_edge && (v_cnt_q == VMax - 10'd1);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (hs_edge)              h_cnt_d = '0;
    else if (h_cnt_q != HMax) h_cnt_d = h_cnt_q + 11'd1;
    if (vs_edge)                          v_cnt_d = '0;
    else if (hs_edge && v_cnt_q != VMax)  v_cnt_d = v_cnt_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      line_len_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      if (hs_edge) line_len_q <= meas_len;
    end
  end

  rx_state_e   state_q;
  logic [10:0] ref_len_q;
  logic [3:0]  frames_q;
  logic        locked_q, err_q, len_bad, drop;

  // ref_len of zero marks "first line of MEASURE not yet seen".
  assign len_bad = hs_edge && (ref_len_q != '0) && (meas_len != ref_len_q);
  assign drop    = h_timeout || v_ovf || len_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StSearch;
      ref_len_q <= '0;
      frames_q  <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StSearch: begin
          ref_len_q <= '0;
          frames_q  <= '0;
          if (!h_timeout && vs_edge) state_q <= StMeasure;
        end
        StMeasure: begin
          if (drop) begin
            state_q <= StSearch;
            err_q   <= 1'b1;
          end else begin
            if (hs_edge && ref_len_q == '0) ref_len_q <= meas_len;
            if (vs_edge) begin
              frames_q <= frames_q + 4'd1;
              if (frames_q == LockW - 4'd1) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
              end
            end
          end
        end
        StLocked: begin
          if (drop) begin
            state_q  <= StSearch;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
          end
        end
        default: begin
          state_q  <= StSearch;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  logic             active;
  logic [9:0]       pix_x_q;
  logic [8:0]       pix_y_q;
  logic [RGB_W-1:0] pix_rgb_q;
  logic             pix_valid_q, frame_start_q;

  assign active = (state_q == StLocked) && (h_cnt_q >= HBegW) && (h_cnt_q < HEndW) &&
                  (v_cnt_q >= VBegW) && (v_cnt_q < VEndW);

  always_ff @(posedge clk) begin
    if (rst || !active) begin
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_x_q       <= 10'(h_cnt_q - HBegW);
      pix_y_q       <= 9'(v_cnt_q - VBegW);
      pix_rgb_q     <= rgb_s1;
      pix_valid_q   <= 1'b1;
      frame_start_q <= (h_cnt_q == HBegW) && (v_cnt_q == VBegW);
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign line_len    = line_len_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver: 800-clock lines with a shortened 5-line frame.
module tb_vga_sync_receiver;

  localparam int LINE    = 800;
  localparam int HSW     = 96;
  localparam int HB      = 48;
  localparam int HA      = 640;
  localparam int VB      = 1;
  localparam int VA      = 2;
  localparam int VS_LINE = 4;
  localparam int HOLD    = 2300;
`ifdef VGA_RX_SYNC2FF_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0, rst = 1'b1, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [8:0] rgb_in = '0;
  logic [9:0] pix_x;
  logic [8:0] pix_y, pix_rgb;
  logic       pix_valid, frame_start, locked, err;
  logic [10:0] line_len;

  vga_sync_receiver #(
    .HActive(HA),
    .HBack  (HB),
    .VActive(VA),
    .VBack  (VB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .rgb_in     (rgb_in),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .locked     (locked),
    .line_len   (line_len),
    .err        (err)
  );

  typedef struct {
    int c;
    int x;
    int y;
    int rgb;
    bit fs;
  } pix_t;

  pix_t pq[$];
  int   eq[$];
  int   cyc = 0, n_chk = 0, n_fail = 0, fr = 0;
  bit   done = 1'b0;

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [8:0] pat(int q, int p);
    int v;
    v = (p * 7) ^ (q * 37) ^ (fr * 101);
    return v[8:0];
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a pixel or an error pulse.
  always @(negedge clk) begin
    if (!done) begin
      if (pix_valid) begin
        if (pq.size() == 0) check("unexpected_pix_valid", 1, 0);
        else begin
          pix_t e;
          e = pq.pop_front();
          check("pix_cycle", cyc, e.c);
          check("pix_x", int'(pix_x), e.x);
          check("pix_y", int'(pix_y), e.y);
          check("pix_rgb", int'(pix_rgb), e.rgb);
          check("frame_start", int'(frame_start), int'(e.fs));
        end
      end else if (frame_start) check("frame_start_without_valid", 1, 0);
      if (err) begin
        if (eq.size() == 0) check("unexpected_err", 1, 0);
        else check("err_cycle", cyc, eq.pop_front());
      end
    end
  end

  // One input clock of the stream; expected pixel/err pushed with its output cycle.
  task automatic drive_slot(input int q, input int p, input int len, input bit exp,
                            input int err_p);
    logic [8:0] c;
    @(negedge clk);
    c        = pat(q, p);
    hsync_in = (p >= len - HSW) ? 1'b0 : 1'b1;
    vsync_in = (q == VS_LINE) ? 1'b0 : 1'b1;
    rgb_in   = c;
    if (exp && p >= HB + 1 && p <= HB + HA && q >= VB && q < VB + VA)
      pq.push_back('{cyc + LAT, p - HB - 1, q - VB, int'(c), (p == HB + 1 && q == VB)});
    if (p == err_p) eq.push_back(cyc + LAT);
  endtask

  task automatic send_line(input int q, input int len, input bit exp, input int err_p);
    for (int p = 0; p < len; p++) drive_slot(q, p, len, exp, err_p);
  endtask

  task automatic send_frame(input bit exp, input bit long3);
    fr++;
    for (int q = 0; q < 5; q++)
      send_line(q, (long3 && q == 3) ? LINE + 1 : LINE, exp, (long3 && q == 4) ? 0 : -1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_valid"}, int'(pix_valid), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_line_len"}, int'(line_len), 0);
    check({tag, "_pix_xyrgb"}, int'({pix_x, pix_y, pix_rgb}), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    send_line(VS_LINE, LINE, 1'b0, -1);
    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    check("locked_after_1_frame", int'(locked), 0);
    fr++;
    send_line(0, LINE, 1'b1, -1);
    check("locked_after_2_frames", int'(locked), 1);
    check("line_len_nominal", int'(line_len), 800);
    for (int q = 1; q < 5; q++) send_line(q, LINE, 1'b1, -1);

    send_frame(1'b1, 1'b1);
    check("locked_after_long_line", int'(locked), 0);
    check("line_len_long", int'(line_len), 801);
    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    check("locked_relock_early", int'(locked), 0);

    fr++;
    send_line(0, LINE, 1'b1, -1);
    check("locked_relock", int'(locked), 1);
    for (int q = 1; q < 5; q++) send_line(q, LINE, 1'b1, -1);

    fr++;
    for (int q = 0; q < 3; q++) send_line(q, LINE, 1'b1, -1);
    send_line(3, HOLD, 1'b0, 2047);
    check("locked_after_timeout", int'(locked), 0);
    send_line(4, LINE, 1'b0, -1);

    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    fr++;
    send_line(0, LINE, 1'b1, -1);
    check("locked_before_reset", int'(locked), 1);
    for (int p = 0; p < 300; p++) drive_slot(1, p, LINE, 1'b1, -1);
    rst = 1'b1;
    while (pq.size() > 0 && pq[$].c > cyc) void'(pq.pop_back());
    for (int p = 300; p < 303; p++) begin
      drive_slot(1, p, LINE, 1'b0, -1);
      if (p == 300) check_zero("midreset");
    end
    rst = 1'b0;
    for (int p = 303; p < LINE; p++) drive_slot(1, p, LINE, 1'b0, -1);
    for (int q = 2; q < 5; q++) send_line(q, LINE, 1'b0, -1);

    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    check("locked_post_reset_early", int'(locked), 0);
    fr++;
    send_line(0, LINE, 1'b1, -1);
    check("locked_post_reset", int'(locked), 1);
    check("line_len_post_reset", int'(line_len), 800);
    for (int q = 1; q < 5; q++) send_line(q, LINE, 1'b1, -1);

    repeat (LAT + 2) @(negedge clk);
    done = 1'b1;
    check("pixels_outstanding", pq.size(), 0);
    check("errs_outstanding", eq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
